// File: rtl/sc_plateau_detector.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sc_plateau_detector
//
// Division-free Schmidl-Cox detection back end. Each input beat carries a
// sample together with its aligned correlation P(d) = {P_I, P_Q} and energy
// R(d). The metric M(d) = |P|^2 / R^2 is compared against a fixed-point
// threshold by cross-multiplication (|P|^2 * 2^THR_FRAC >= thr * R^2). A
// plateau FSM looks for a run of above-threshold beats of at least
// cfg_min_len and flags the first beat after the plateau (the symbol start)
// on o_tuser, then ignores cfg_holdoff beats.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   clear           synchronous flush, same effect as reset
//   cfg_threshold   unsigned threshold, THR_FRAC fractional bits
//   cfg_min_len     minimum plateau length in beats (0 acts as 1)
//   cfg_holdoff     beats ignored after a detection
//   i_tdata/i_p/i_r/i_tlast/i_tvalid/i_tready   input beat (AXI-Stream style)
//   o_tdata/o_tuser/o_above/o_tlast/o_tvalid/o_tready  output beat
//   det_count       saturating count of detections
//
// Pipeline: 3 register stages sharing one enable (en = ~o_tvalid | o_tready),
// so a stalled output freezes every stage and i_tready equals en.
// -----------------------------------------------------------------------------
module sc_plateau_detector #(
  parameter int SAMPLE_W = 32,
  parameter int P_W      = 16,
  parameter int R_W      = 16,
  parameter int THR_W    = 16,
  parameter int THR_FRAC = 15,
  parameter int LEN_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic [THR_W-1:0]    cfg_threshold,
  input  logic [LEN_W-1:0]    cfg_min_len,
  input  logic [LEN_W-1:0]    cfg_holdoff,
  input  logic [SAMPLE_W-1:0] i_tdata,
  input  logic [2*P_W-1:0]    i_p,
  input  logic [R_W-1:0]      i_r,
  input  logic                i_tlast,
  input  logic                i_tvalid,
  output logic                i_tready,
  output logic [SAMPLE_W-1:0] o_tdata,
  output logic                o_tuser,
  output logic                o_above,
  output logic                o_tlast,
  output logic                o_tvalid,
  input  logic                o_tready,
  output logic [15:0]         det_count
);

  // Compare width wide enough for both sides of the cross-multiplication.
  localparam int LHS_W = 2*P_W + THR_FRAC;
  localparam int RHS_W = 2*R_W + THR_W;
  localparam int CMP_W = (LHS_W > RHS_W) ? LHS_W : RHS_W;

  typedef enum logic [1:0] {ST_SEARCH, ST_RUN, ST_HOLD} state_t;

  logic en;
  logic flush;

  assign en       = ~o_tvalid | o_tready;
  assign i_tready = en;
  assign flush    = reset | clear;

  // ---------------- Stage 1: register inputs ----------------
  logic                s1_valid_q;
  logic [SAMPLE_W-1:0] s1_data_q;
  logic [2*P_W-1:0]    s1_p_q;
  logic [R_W-1:0]      s1_r_q;
  logic                s1_last_q;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every stage samples the previous stage's value from before the edge.
  always_ff @(posedge clk) begin
    if (flush) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_p_q     <= '0;
      s1_r_q     <= '0;
      s1_last_q  <= 1'b0;
    end else if (en) begin
      s1_valid_q <= i_tvalid;
      s1_data_q  <= i_tdata;
      s1_p_q     <= i_p;
      s1_r_q     <= i_r;
      s1_last_q  <= i_tlast;
    end
  end

  // ---------------- Stage 2: |P|^2 and R^2 ----------------
  logic signed [2*P_W-1:0] p_i_ext, p_q_ext;
  logic signed [2*P_W-1:0] p_i_sq, p_q_sq;
  logic        [2*P_W-1:0] magp_c;
  logic        [2*R_W-1:0] r_ext, r2_c;

  assign p_i_ext = {{P_W{s1_p_q[2*P_W-1]}}, s1_p_q[2*P_W-1:P_W]};
  assign p_q_ext = {{P_W{s1_p_q[P_W-1]}},   s1_p_q[P_W-1:0]};
  assign p_i_sq  = p_i_ext * p_i_ext;
  assign p_q_sq  = p_q_ext * p_q_ext;
  // Each square is at most 2^(2*P_W-2), so the unsigned sum cannot overflow.
  assign magp_c  = $unsigned(p_i_sq) + $unsigned(p_q_sq);
  assign r_ext   = {{R_W{1'b0}}, s1_r_q};
  assign r2_c    = r_ext * r_ext;

  logic                s2_valid_q;
  logic [SAMPLE_W-1:0] s2_data_q;
  logic                s2_last_q;
  logic [2*P_W-1:0]    s2_magp_q;
  logic [2*R_W-1:0]    s2_r2_q;

  always_ff @(posedge clk) begin
    if (flush) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_last_q  <= 1'b0;
      s2_magp_q  <= '0;
      s2_r2_q    <= '0;
    end else if (en) begin
      s2_valid_q <= s1_valid_q;
      s2_data_q  <= s1_data_q;
      s2_last_q  <= s1_last_q;
      s2_magp_q  <= magp_c;
      s2_r2_q    <= r2_c;
    end
  end

  // ---------------- Stage 3: threshold compare + plateau FSM ----------------
  logic [CMP_W-1:0] lhs_c, rhs_c;
  logic             above_c;

  assign lhs_c   = CMP_W'(s2_magp_q) << THR_FRAC;
  assign rhs_c   = CMP_W'(cfg_threshold) * CMP_W'(s2_r2_q);
  // R == 0 would make every metric pass; force it below threshold instead.
  assign above_c = (lhs_c >= rhs_c) && (s2_r2_q != '0);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] run_q, run_d;
  logic [LEN_W-1:0] hold_q, hold_d;
  logic [15:0]      det_q, det_d;
  logic             tuser_c;
  logic             step;
  logic [LEN_W-1:0] min_len_eff;

  // FSM advances only for a valid beat actually entering stage 3.
  assign step        = en & s2_valid_q;
  assign min_len_eff = (cfg_min_len == '0) ? LEN_W'(1) : cfg_min_len;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    hold_d  = hold_q;
    det_d   = det_q;
    tuser_c = 1'b0;
    if (step) begin
      unique case (state_q)
        ST_SEARCH: begin
          if (above_c) begin
            state_d = ST_RUN;
            run_d   = LEN_W'(1);
          end
        end
        ST_RUN: begin
          if (above_c) begin
            if (run_q != '1) run_d = run_q + LEN_W'(1);
          end else if (run_q >= min_len_eff) begin
            tuser_c = 1'b1;
            run_d   = '0;
            if (det_q != 16'hFFFF) det_d = det_q + 16'd1;
            if (cfg_holdoff == '0) begin
              state_d = ST_SEARCH;
            end else begin
              hold_d  = cfg_holdoff;
              state_d = ST_HOLD;
            end
          end else begin
            run_d   = '0;
            state_d = ST_SEARCH;
          end
        end
        ST_HOLD: begin
          // Leave after the beat on which the counter reaches zero.
          if (hold_q <= LEN_W'(1)) begin
            hold_d  = '0;
            state_d = ST_SEARCH;
          end else begin
            hold_d  = hold_q - LEN_W'(1);
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      state_q  <= ST_SEARCH;
      run_q    <= '0;
      hold_q   <= '0;
      det_q    <= '0;
      o_tvalid <= 1'b0;
      o_tdata  <= '0;
      o_tlast  <= 1'b0;
      o_tuser  <= 1'b0;
      o_above  <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      hold_q  <= hold_d;
      det_q   <= det_d;
      if (en) begin
        o_tvalid <= s2_valid_q;
        o_tdata  <= s2_data_q;
        o_tlast  <= s2_last_q;
        o_above  <= s2_valid_q & above_c;
        o_tuser  <= tuser_c;
      end
    end
  end

  assign det_count = det_q;

endmodule

// File: tb/tb_sc_plateau_detector.sv
`timescale 1ns/1ps
// Self-checking bench for sc_plateau_detector. A behavioural model computes
// the expected above/tuser for every beat as it is driven; expectations are
// queued and compared when the beat leaves the DUT.
module tb_sc_plateau_detector;

  localparam int SAMPLE_W = 32;
  localparam int P_W      = 16;
  localparam int R_W      = 16;
  localparam int THR_W    = 16;
  localparam int THR_FRAC = 15;
  localparam int LEN_W    = 16;

  logic                clk;
  logic                reset;
  logic                clear;
  logic [THR_W-1:0]    cfg_threshold;
  logic [LEN_W-1:0]    cfg_min_len;
  logic [LEN_W-1:0]    cfg_holdoff;
  logic [SAMPLE_W-1:0] i_tdata;
  logic [2*P_W-1:0]    i_p;
  logic [R_W-1:0]      i_r;
  logic                i_tlast;
  logic                i_tvalid;
  logic                i_tready;
  logic [SAMPLE_W-1:0] o_tdata;
  logic                o_tuser;
  logic                o_above;
  logic                o_tlast;
  logic                o_tvalid;
  logic                o_tready;
  logic [15:0]         det_count;

  sc_plateau_detector #(
    .SAMPLE_W(SAMPLE_W), .P_W(P_W), .R_W(R_W),
    .THR_W(THR_W), .THR_FRAC(THR_FRAC), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .cfg_threshold(cfg_threshold), .cfg_min_len(cfg_min_len), .cfg_holdoff(cfg_holdoff),
    .i_tdata(i_tdata), .i_p(i_p), .i_r(i_r), .i_tlast(i_tlast),
    .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tuser(o_tuser), .o_above(o_above), .o_tlast(o_tlast),
    .o_tvalid(o_tvalid), .o_tready(o_tready), .det_count(det_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [SAMPLE_W-1:0] data;
    logic                last;
    logic                user;
    logic                above;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   beat_idx = 0;
  bit   rand_ready = 1'b0;
  bit   gap_mode   = 1'b0;

  // Reference plateau model
  int          m_state = 0;  // 0 search, 1 run, 2 hold
  int unsigned m_run   = 0;
  int unsigned m_hold  = 0;
  int unsigned m_det   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_above(input int pi, input int pq, input int r);
    longint unsigned magp, lhs, rhs;
    magp = longint'(pi) * longint'(pi) + longint'(pq) * longint'(pq);
    lhs  = magp << THR_FRAC;
    rhs  = 64'(cfg_threshold) * 64'(r) * 64'(r);
    return (r != 0) && (lhs >= rhs);
  endfunction

  task automatic model_step(input bit above, output bit tuser);
    int unsigned minl;
    minl  = (cfg_min_len == 0) ? 1 : int'(cfg_min_len);
    tuser = 1'b0;
    case (m_state)
      0: if (above) begin m_state = 1; m_run = 1; end
      1: begin
        if (above) begin
          if (m_run < 65535) m_run++;
        end else if (m_run >= minl) begin
          tuser = 1'b1;
          if (m_det < 65535) m_det++;
          if (cfg_holdoff == 0) m_state = 0;
          else begin m_hold = cfg_holdoff; m_state = 2; end
        end else begin
          m_state = 0;
        end
      end
      default: begin
        m_hold--;
        if (m_hold == 0) m_state = 0;
      end
    endcase
  endtask

  task automatic model_reset();
    m_state = 0; m_run = 0; m_hold = 0; m_det = 0;
  endtask

  // Put a beat on the input bus and queue its expected output.
  task automatic prep_beat(input int pi, input int pq, input int r,
                           input logic [SAMPLE_W-1:0] data, input bit last);
    exp_t e;
    bit   a, u;
    i_tdata  = data;
    i_p      = {16'(pi), 16'(pq)};
    i_r      = 16'(r);
    i_tlast  = last;
    i_tvalid = 1'b1;
    a = model_above(pi, pq, r);
    model_step(a, u);
    e.data = data; e.last = last; e.user = u; e.above = a;
    sb.push_back(e);
    beat_idx++;
  endtask

  // Entered and left at posedge+1.
  task automatic send(input int pi, input int pq, input int r);
    bit hs;
    if (gap_mode && $urandom_range(1, 0) == 1) begin
      i_tvalid = 1'b0;
      repeat ($urandom_range(3, 1)) begin @(posedge clk); #1; end
    end
    prep_beat(pi, pq, r, 32'h5A00_0000 + 32'(beat_idx), (beat_idx % 8) == 7);
    hs = 1'b0;
    for (int c = 0; c < 200 && !hs; c++) begin
      @(negedge clk);
      hs = i_tready;
      @(posedge clk); #1;
    end
    check("handshake", 64'(hs), 64'd1);
  endtask

  task automatic send_above(input int n);
    for (int k = 0; k < n; k++) send(100, 0, 100);
  endtask

  task automatic send_below(input int n);
    for (int k = 0; k < n; k++) send(50, 0, 100);
  endtask

  task automatic idle(input int n);
    i_tvalid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    i_tvalid = 1'b0;
    for (int c = 0; c < 1000 && sb.size() != 0; c++) begin @(posedge clk); #1; end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Downstream ready generator.
  initial begin
    o_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      o_tready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
    end
  end

  // Output monitor: pops on every accepted output beat.
  always @(negedge clk) begin
    if (!reset && o_tvalid && o_tready) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("o_tdata", 64'(o_tdata), 64'(mon_e.data));
        check("o_tlast", 64'(o_tlast), 64'(mon_e.last));
        check("o_tuser", 64'(o_tuser), 64'(mon_e.user));
        check("o_above", 64'(o_above), 64'(mon_e.above));
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset         = 1'b1;
    clear         = 1'b0;
    cfg_threshold = 16'h4000;
    cfg_min_len   = 16'd8;
    cfg_holdoff   = 16'd0;
    i_tdata       = 32'hDEAD_BEEF;
    i_p           = 32'h0064_0000;
    i_r           = 16'd100;
    i_tlast       = 1'b1;
    i_tvalid      = 1'b1;

    // ---- Reset state ----
    repeat (3) @(posedge clk);
    #1;
    check("rst_o_tvalid", 64'(o_tvalid), 64'd0);
    check("rst_o_tdata",  64'(o_tdata),  64'd0);
    check("rst_o_tuser",  64'(o_tuser),  64'd0);
    check("rst_o_above",  64'(o_above),  64'd0);
    check("rst_o_tlast",  64'(o_tlast),  64'd0);
    check("rst_det",      64'(det_count), 64'd0);
    reset    = 1'b0;
    i_tvalid = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", 64'(i_tready), 64'd1);

    // ---- Latency: one beat, o_tvalid after exactly 3 edges ----
    prep_beat(100, 0, 100, 32'hCAFE_0001, 1'b1);
    @(negedge clk);
    check("lat_ready", 64'(i_tready), 64'd1);
    @(posedge clk); #1;           // handshake edge
    i_tvalid = 1'b0;
    check("lat_edge1", 64'(o_tvalid), 64'd0);
    @(posedge clk); #1;
    check("lat_edge2", 64'(o_tvalid), 64'd0);
    @(posedge clk); #1;
    check("lat_edge3", 64'(o_tvalid), 64'd1);
    check("lat_tdata", 64'(o_tdata), 64'hCAFE_0001);
    check("lat_tlast", 64'(o_tlast), 64'd1);
    idle(3);

    // ---- Threshold compare: above, below, R == 0 ----
    send(100, 0, 100);
    send(50, 0, 100);
    send(100, 0, 0);
    drain();
    check("det_thr", 64'(det_count), 64'(m_det));

    // ---- min_len 8, holdoff 0: 8-beat plateau detected, 7-beat not ----
    send_below(10); send_above(8); send_below(1);
    send_below(10); send_above(7); send_below(1);
    drain();
    check("det_minlen", 64'(det_count), 64'(m_det));

    // ---- holdoff 4: two detections ----
    cfg_holdoff = 16'd4;
    send_below(10); send_above(8); send_below(1); send_above(12); send_below(3);
    drain();
    check("det_holdoff", 64'(det_count), 64'(m_det));

    // ---- same stimulus with random stalls and gaps ----
    rand_ready = 1'b1;
    gap_mode   = 1'b1;
    send_below(10); send_above(8); send_below(1); send_above(12); send_below(3);
    drain();
    rand_ready = 1'b0;
    gap_mode   = 1'b0;
    idle(2);
    check("det_stall", 64'(det_count), 64'(m_det));

    // ---- clear mid-plateau ----
    send_below(6);
    send_above(14);
    i_tvalid = 1'b0;
    clear    = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    sb.delete();
    model_reset();
    check("clr_o_tvalid", 64'(o_tvalid), 64'd0);
    check("clr_det", 64'(det_count), 64'd0);
    send_above(8); send_below(2);
    drain();
    check("det_after_clr", 64'(det_count), 64'(m_det));
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sc_plateau_detector.md
Name: sc_plateau_detector

Overview:
- Division-free successor to the Schmidl-Cox metric/detection path.
- Takes an aligned beat carrying the sample, the correlation P(d) and the energy R(d).
- Tests M(d) = |P|^2/R^2 against a runtime threshold by cross-multiplication, so no divider IP is needed.
- Runs a plateau state machine with runtime minimum length and holdoff, and tags the detected symbol start on the outgoing sample stream via tuser.

Parameters:
SAMPLE_W, 32, width of the passthrough sample (sc16 I/Q)
P_W, 16, width of each signed component of P (I in upper half, Q in lower half)
R_W, 16, width of unsigned R
THR_W, 16, width of unsigned threshold
THR_FRAC, 15, fractional bits of threshold (threshold 2^THR_FRAC = 1.0)
LEN_W, 16, width of the run/holdoff counters and configs

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
clear  in  1  synchronous flush, same effect as reset
cfg_threshold  in  THR_W  unsigned fixed-point threshold, quasi-static
cfg_min_len  in  LEN_W  minimum plateau length in beats (0 treated as 1)
cfg_holdoff  in  LEN_W  beats ignored after a detection
i_tdata  in  SAMPLE_W  sample aligned with P/R
i_p  in  2*P_W  {P_I, P_Q} signed
i_r  in  R_W  unsigned energy
i_tlast  in  1  packet boundary
i_tvalid  in  1  beat valid
i_tready  out  1  beat accepted
o_tdata  out  SAMPLE_W  delayed sample
o_tuser  out  1  start-of-symbol flag
o_above  out  1  metric-above-threshold bit for this beat
o_tlast  out  1  delayed tlast
o_tvalid  out  1  output valid
o_tready  in  1  downstream ready
det_count  out  16  saturating detection counter

Behaviour:
- Pipeline: 3 stages with a global enable, en = ~o_tvalid | o_tready.
  - i_tready = en.
  - Every stage (data, tlast, valid bit) advances only when en.
  - Latency: 3 cycles from input handshake to o_tvalid when unstalled.
  - Stalls freeze all stages; no beat is dropped or duplicated.
  - Bubbles propagate as invalid stages.
- Stage 1: register inputs.
- Stage 2:
  - magp = P_I^2 + P_Q^2, unsigned, 2*P_W bits (cannot overflow).
  - r2 = R^2, 2*R_W bits.
- Stage 3:
  - lhs = magp << THR_FRAC.
  - rhs = cfg_threshold * r2.
  - Compare at max(2*P_W+THR_FRAC, 2*R_W+THR_W) bits, zero-extended.
  - above = (lhs >= rhs) & (r2 != 0); R == 0 forces above = 0.
- FSM: updates once per valid beat loading stage 3, and uses that beat's above.
  - SEARCH: if above, go to RUN with run_cnt = 1.
  - RUN, above: run_cnt++, saturating at 2^LEN_W-1.
  - RUN, not above and run_cnt >= max(cfg_min_len,1):
    - Set o_tuser on this beat and increment det_count (saturating at 0xFFFF).
    - Load hold_cnt = cfg_holdoff and go to HOLD; go to SEARCH instead if cfg_holdoff == 0.
  - RUN, not above otherwise: go to SEARCH.
  - HOLD: ignore above and decrement hold_cnt each beat; leave for SEARCH after the beat on which hold_cnt reaches 0, so exactly cfg_holdoff beats are ignored.
  - tlast does not affect the FSM; plateaus span packets.
- o_tuser and o_above are registered together with the beat in stage 3.
  - Bubbles never carry a flag or change the FSM.
- Reset/clear:
  - All stage valids = 0; FSM = SEARCH; run_cnt = hold_cnt = 0; det_count = 0.
  - o_tdata, o_tuser, o_above, o_tlast, o_tvalid = 0.
  - i_tready = 1 on the cycle after reset.
  - Mid-operation clear discards in-flight beats, including a pending detection.
- Config: cfg_threshold is sampled at stage 3 per beat. cfg_min_len and cfg_holdoff are sampled when used. Changes mid-plateau are legal but their effect is undefined for that plateau.

Test Plan:
- Reset, then one beat with o_tready = 1 -> all outputs 0 during reset; i_tready = 1; o_tvalid high exactly 3 cycles after the input handshake with unchanged tdata/tlast.
- Threshold 0x4000 (0.5) -> P=(100,0), R=100 gives o_above = 1 (327,680,000 >= 163,840,000); P=(50,0), R=100 gives o_above = 0; P=(100,0), R=0 gives o_above = 0.
- min_len = 8, holdoff = 0 -> 10 below, 8 above, then below: o_tuser on beat 18 only, det_count = 1. Repeating with 7 above beats gives no flag.
- min_len = 8, holdoff = 4 -> 10 below, 8 above, 1 below, 12 above, then below: o_tuser on beats 18 and 31 (run counted over beats 23-30), det_count = 2.
- Random o_tready (50%) and random i_tvalid gaps on test 4 stimulus -> output beat sequence, tuser and tlast identical to the unstalled run.
- Clear asserted at beat 14 of a plateau -> o_tvalid = 0 next cycle; det_count = 0; a subsequent 8-beat plateau is detected normally.
